// File: rtl/mod_pkg.sv
// Shared definitions for the baseband symbol source and its PRBS generator.
// Contents: mode encodings, run-state enum, captured-config struct, PRBS7
// tap positions and default seed, amplitude ceiling, and sample-mapping helpers.
package mod_pkg;

  localparam logic [1:0] MODE_PRBS7 = 2'd0;
  localparam logic [1:0] MODE_PAT   = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  // x^7 + x^6 + 1
  localparam int         PRBS_TAP_A    = 6;
  localparam int         PRBS_TAP_B    = 5;
  localparam logic [6:0] PRBS_SEED_DEF = 7'h7F;

  localparam logic [14:0] AMP_MAX = 15'h7FFF;  // 32767

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Configuration frozen at the start of each run
  typedef struct packed {
    logic [1:0]  mode;     // already normalised: reserved 3 becomes CONST
    logic [31:0] pattern;
    logic [4:0]  pat_len;
    logic [31:0] sym_div;
    logic [14:0] amp;      // saturated magnitude
    logic        ook;
  } cfg_t;

  // A magnitude with bit 15 set is clipped to the largest positive value, so
  // negation can never reach -32768.
  function automatic logic [14:0] sat_amp(input logic [15:0] amp);
    return amp[15] ? AMP_MAX : amp[14:0];
  endfunction

  function automatic logic [15:0] map_sample(input logic b, input logic [14:0] amp,
                                             input logic ook);
    if (b)        return {1'b0, amp};
    else if (ook) return 16'd0;
    else          return 16'd0 - {1'b0, amp};
  endfunction

endpackage

// File: rtl/mod_symbol_gen_if.sv
// Output stream from the symbol source to the modulator data input.
//   o_valid      sample valid
//   o_data       signed sample
//   o_sym_strobe first cycle of each symbol
//   o_bit        current symbol bit (debug)
// master = symbol source, slave = modulator / observer.
interface mod_symbol_gen_if #(
  parameter int DATA_W = 16
);
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_sym_strobe;
  logic                     o_bit;

  modport master (output o_valid, o_data, o_sym_strobe, o_bit);
  modport slave  (input  o_valid, o_data, o_sym_strobe, o_bit);
endinterface

// File: rtl/mod_prbs7.sv
// PRBS7 (x^7+x^6+1) bit source. Reusable by a demodulator-side BER checker.
//   clk, rst    clock, synchronous active-high reset (loads SEED)
//   i_load      reload SEED
//   i_advance   step the sequence by one bit
//   o_bit       current bit (lfsr[6])
//   o_next_bit  bit that becomes current after the next advance (lfsr[5])
module mod_prbs7 import mod_pkg::*; #(
  parameter logic [6:0] SEED = PRBS_SEED_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_advance,
  output logic o_bit,
  output logic o_next_bit
);
  logic [6:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst || i_load)
      lfsr_q <= SEED;
    else if (i_advance)
      lfsr_q <= {lfsr_q[5:0], lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B]};
  end

  assign o_bit      = lfsr_q[6];
  assign o_next_bit = lfsr_q[5];
endmodule

// File: rtl/mod_symbol_gen.sv
// Baseband symbol source feeding the modulator's signed 16-bit data input.
// Bits come from PRBS7, a 32-bit pattern or a constant; each bit is held for
// sym_div+1 clocks and mapped to +amp / -amp (or 0 in OOK).
//   clk, rst      clock, synchronous active-high reset
//   i_enable      rising edge starts a run, low stops it
//   i_mode        0 PRBS7, 1 pattern, 2/3 constant
//   i_pattern     pattern bits, bit 0 first
//   i_pat_len     pattern length minus 1
//   i_sym_div     clocks per symbol minus 1
//   i_amp         unsigned amplitude (bit 15 set saturates to 32767)
//   i_ook         bit 0 maps to 0 instead of -amp
//   out_if        output stream (valid, data, strobe, bit)
module mod_symbol_gen import mod_pkg::*; #(
  parameter int         DATA_W = 16,
  parameter logic [6:0] SEED   = PRBS_SEED_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [1:0]              i_mode,
  input  logic [31:0]             i_pattern,
  input  logic [4:0]              i_pat_len,
  input  logic [31:0]             i_sym_div,
  input  logic [15:0]             i_amp,
  input  logic                    i_ook,
  mod_symbol_gen_if.master        out_if
);
  state_t                   state_q;
  cfg_t                     cfg_q, cfg_in;
  logic                     en_q;
  logic [31:0]              cnt_q;
  logic [4:0]               idx_q, idx_nxt;
  logic                     valid_q, strobe_q, bit_q;
  logic signed [DATA_W-1:0] data_q;

  logic start, wrap, first_bit, cur_bit, nxt_bit, bit_d;
  logic prbs_bit, prbs_next, prbs_load, prbs_adv;

  always_comb begin
    cfg_in.mode    = (i_mode == 2'd3) ? MODE_CONST : i_mode;
    cfg_in.pattern = i_pattern;
    cfg_in.pat_len = i_pat_len;
    cfg_in.sym_div = i_sym_div;
    cfg_in.amp     = sat_amp(i_amp);
    cfg_in.ook     = i_ook;
  end

  assign start   = i_enable && !en_q;
  assign wrap    = (cnt_q == cfg_q.sym_div);
  assign idx_nxt = (idx_q == cfg_q.pat_len) ? 5'd0 : idx_q + 5'd1;

  // The LFSR only loads on the start edge, so the first symbol is taken from
  // SEED directly to make it visible in the very next cycle.
  assign first_bit = (cfg_in.mode == MODE_PRBS7) ? SEED[6] : i_pattern[0];

  // Output registers are fed with the bit the source will hold after this
  // edge: the current bit between wraps, the look-ahead bit on a wrap.
  always_comb begin
    cur_bit = cfg_q.pattern[0];
    nxt_bit = cfg_q.pattern[0];
    case (cfg_q.mode)
      MODE_PRBS7: begin cur_bit = prbs_bit;               nxt_bit = prbs_next;               end
      MODE_PAT:   begin cur_bit = cfg_q.pattern[idx_q];   nxt_bit = cfg_q.pattern[idx_nxt];   end
      default:    ;
    endcase
    bit_d = wrap ? nxt_bit : cur_bit;
  end

  assign prbs_load = (state_q == ST_IDLE) && start;
  assign prbs_adv  = (state_q == ST_RUN) && i_enable && wrap && (cfg_q.mode == MODE_PRBS7);

  mod_prbs7 #(.SEED(SEED)) u_prbs (
    .clk        (clk),
    .rst        (rst),
    .i_load     (prbs_load),
    .i_advance  (prbs_adv),
    .o_bit      (prbs_bit),
    .o_next_bit (prbs_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      bit_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      en_q <= i_enable;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_RUN;
            cfg_q    <= cfg_in;
            cnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
            bit_q    <= first_bit;
            data_q   <= map_sample(first_bit, cfg_in.amp, cfg_in.ook);
          end else begin
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            bit_q    <= 1'b0;
            data_q   <= '0;
          end
        end
        default: begin
          if (!i_enable) begin
            // Stop wins over a coincident wrap: no new symbol is emitted.
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            bit_q    <= 1'b0;
            data_q   <= '0;
          end else begin
            valid_q  <= 1'b1;
            strobe_q <= wrap;
            bit_q    <= bit_d;
            data_q   <= map_sample(bit_d, cfg_q.amp, cfg_q.ook);
            if (wrap) begin
              cnt_q <= '0;
              idx_q <= idx_nxt;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
      endcase
    end
  end

  assign out_if.o_valid      = valid_q;
  assign out_if.o_data       = data_q;
  assign out_if.o_sym_strobe = strobe_q;
  assign out_if.o_bit        = bit_q;
endmodule

// File: tb/tb_mod_symbol_gen.sv
module tb_mod_symbol_gen;
  logic        clk = 1'b0;
  logic        r_rst = 1'b1, r_en = 1'b0, r_ook = 1'b0;
  logic [1:0]  r_mode = '0;
  logic [31:0] r_pat = '0, r_div = '0;
  logic [4:0]  r_len = '0;
  logic [15:0] r_amp = '0;

  always #5 clk = ~clk;

  mod_symbol_gen_if #(.DATA_W(16)) sif ();

  mod_symbol_gen #(.DATA_W(16), .SEED(7'h7F)) dut (
    .clk       (clk),
    .rst       (r_rst),
    .i_enable  (r_en),
    .i_mode    (r_mode),
    .i_pattern (r_pat),
    .i_pat_len (r_len),
    .i_sym_div (r_div),
    .i_amp     (r_amp),
    .i_ook     (r_ook),
    .out_if    (sif.master)
  );

  int vectors = 0, miscompares = 0;

  // Reference: PRBS7 as a bit sequence s[n] = s[n-7] ^ s[n-6], first 7 bits 1.
  bit prbs [127];

  // Run bookkeeping: whether a run is active and how many cycles since start.
  bit          m_run = 0, m_en_prev = 0;
  longint      m_t = 0;
  int          c_mode = 0, c_len = 0, c_amp = 0;
  longint      c_div = 0;
  logic [31:0] c_pat = '0;
  bit          c_ook = 0;
  logic        e_valid, e_strobe, e_bit;
  logic [15:0] e_data;

  // Advance one clock: update the model with the inputs the DUT sees at this
  // edge, wait for the edge, then form the expected outputs.
  task automatic tick();
    bit     start, b;
    longint n;
    int     v;
    if (r_rst) begin
      m_run = 0; m_en_prev = 0;
    end else begin
      start = r_en && !m_en_prev;
      if (!m_run && start) begin
        c_mode = (r_mode == 2'd0) ? 0 : (r_mode == 2'd1) ? 1 : 2;
        c_pat  = r_pat; c_len = int'(r_len); c_div = longint'(r_div);
        c_amp  = r_amp[15] ? 32767 : int'(r_amp); c_ook = r_ook;
        m_run = 1; m_t = 0;
      end else if (m_run && !r_en) m_run = 0;
      else if (m_run) m_t++;
      m_en_prev = r_en;
    end
    @(posedge clk); #1;
    if (m_run) begin
      n = m_t / (c_div + 1);
      if (c_mode == 0)      b = prbs[n % 127];
      else if (c_mode == 1) b = c_pat[n % (c_len + 1)];
      else                  b = c_pat[0];
      v = b ? c_amp : (c_ook ? 0 : -c_amp);
      e_valid = 1; e_strobe = ((m_t % (c_div + 1)) == 0); e_bit = b; e_data = 16'(v);
    end else begin
      e_valid = 0; e_strobe = 0; e_bit = 0; e_data = '0;
    end
  endtask

  task automatic test_reset();
    r_rst = 1; r_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); vectors++;
      if ({sif.o_valid, sif.o_sym_strobe, sif.o_bit} !== 3'b000 || sif.o_data !== 16'sd0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got v=%b s=%b b=%b d=%0d need all zero", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data);
      end
    end
    r_rst = 0; tick();
  endtask

  task automatic test_prbs();
    r_mode = 2'd0; r_div = 32'd3; r_amp = 16'h4000; r_ook = 0; r_en = 1;
    for (int i = 0; i < 520; i++) begin
      tick(); vectors++;
      if ({sif.o_valid, sif.o_sym_strobe, sif.o_bit} !== {e_valid, e_strobe, e_bit} || sif.o_data !== e_data) begin
        miscompares++;
        $display("FAIL prbs cyc=%0d got v=%b s=%b b=%b d=%0d want v=%b s=%b b=%b d=%0d", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_valid, e_strobe, e_bit, $signed(e_data));
      end
      // Seven 1-symbols of 4 clocks, then a 0-symbol
      if (i < 32) begin
        vectors++;
        if (sif.o_data !== ((i < 28) ? 16'sd16384 : -16'sd16384)) begin
          miscompares++;
          $display("FAIL prbs_head cyc=%0d got d=%0d want %0d", i, sif.o_data, (i < 28) ? 16384 : -16384);
        end
      end
    end
    r_en = 0; tick(); tick();
  endtask

  task automatic test_pattern();
    r_mode = 2'd1; r_pat = 32'h0000_0005; r_len = 5'd3; r_div = 0; r_ook = 1; r_amp = 16'd1000; r_en = 1;
    for (int i = 0; i < 12; i++) begin
      tick(); vectors++;
      if ({sif.o_valid, sif.o_sym_strobe} !== 2'b11 || sif.o_data !== ((i % 2 == 0) ? 16'sd1000 : 16'sd0)
          || sif.o_data !== e_data || sif.o_bit !== e_bit) begin
        miscompares++;
        $display("FAIL pattern cyc=%0d got v=%b s=%b b=%b d=%0d want v=1 s=1 b=%b d=%0d", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_bit, $signed(e_data));
      end
    end
    r_en = 0; tick();
  endtask

  task automatic test_const();
    r_mode = 2'd3; r_pat = 32'hFFFF_FFFE; r_amp = 16'hFFFF; r_ook = 0; r_div = 32'd2; r_en = 1;
    for (int i = 0; i < 15; i++) begin
      tick(); vectors++;
      if (sif.o_data !== -16'sd32767 || sif.o_sym_strobe !== e_strobe || sif.o_valid !== 1'b1 || sif.o_bit !== 1'b0) begin
        miscompares++;
        $display("FAIL const cyc=%0d got v=%b s=%b b=%b d=%0d want v=1 s=%b b=0 d=-32767", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_strobe);
      end
    end
    r_en = 0; tick();
  endtask

  task automatic test_midrun();
    r_mode = 2'd0; r_div = 32'd1; r_amp = 16'd1234; r_ook = 0; r_en = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin r_amp = 16'($urandom); r_mode = 2'd2; r_ook = 1; r_div = 32'd5; end
      if (i == 25) r_en = 0;
      if (i == 27) begin r_en = 1; r_mode = 2'd0; end
      tick(); vectors++;
      if ({sif.o_valid, sif.o_sym_strobe, sif.o_bit} !== {e_valid, e_strobe, e_bit} || sif.o_data !== e_data) begin
        miscompares++;
        $display("FAIL midrun cyc=%0d got v=%b s=%b b=%b d=%0d want v=%b s=%b b=%b d=%0d", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_valid, e_strobe, e_bit, $signed(e_data));
      end
    end
    r_en = 0; tick();
  endtask

  task automatic test_reset_midrun();
    r_mode = 2'd0; r_div = 32'd3; r_amp = 16'd500; r_ook = 0; r_en = 1;
    for (int i = 0; i < 20; i++) begin
      r_rst = (i == 6);
      tick(); vectors++;
      if ({sif.o_valid, sif.o_sym_strobe, sif.o_bit} !== {e_valid, e_strobe, e_bit} || sif.o_data !== e_data) begin
        miscompares++;
        $display("FAIL rst_midrun cyc=%0d got v=%b s=%b b=%b d=%0d want v=%b s=%b b=%b d=%0d", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_valid, e_strobe, e_bit, $signed(e_data));
      end
      if (i == 6 || i == 7) begin
        vectors++;
        if (sif.o_valid !== ((i == 7) ? 1'b1 : 1'b0) || sif.o_data !== ((i == 7) ? 16'sd500 : 16'sd0)) begin
          miscompares++;
          $display("FAIL rst_restart cyc=%0d got v=%b d=%0d", i, sif.o_valid, sif.o_data);
        end
      end
    end
    r_en = 0; tick();
  endtask

  task automatic test_drop_on_wrap();
    r_mode = 2'd1; r_pat = 32'h0000_0002; r_len = 5'd1; r_div = 32'd9; r_amp = 16'd777; r_ook = 0; r_en = 1;
    for (int i = 0; i < 24; i++) begin
      r_en = (i != 10);  // the edge after output cycle 9 is the wrap edge
      tick(); vectors++;
      if ({sif.o_valid, sif.o_sym_strobe, sif.o_bit} !== {e_valid, e_strobe, e_bit} || sif.o_data !== e_data) begin
        miscompares++;
        $display("FAIL drop_wrap cyc=%0d got v=%b s=%b b=%b d=%0d want v=%b s=%b b=%b d=%0d", i,
                 sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_valid, e_strobe, e_bit, $signed(e_data));
      end
      if (i == 10) begin
        vectors++;
        if (sif.o_sym_strobe !== 1'b0 || sif.o_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL drop_wrap_strobe got v=%b s=%b want 0 0", sif.o_valid, sif.o_sym_strobe);
        end
      end
    end
    r_en = 0; tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      r_mode = 2'($urandom); r_pat = $urandom; r_len = 5'($urandom);
      r_div = 32'($urandom_range(0, 3)); r_ook = 1'($urandom);
      r_amp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      r_en = 1;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 15) == 0) r_en = ~r_en;
        tick(); vectors++;
        if ({sif.o_valid, sif.o_sym_strobe, sif.o_bit} !== {e_valid, e_strobe, e_bit} || sif.o_data !== e_data) begin
          miscompares++;
          $display("FAIL random k=%0d cyc=%0d got v=%b s=%b b=%b d=%0d want v=%b s=%b b=%b d=%0d", k, i,
                   sif.o_valid, sif.o_sym_strobe, sif.o_bit, sif.o_data, e_valid, e_strobe, e_bit, $signed(e_data));
        end
      end
      r_en = 0; tick();
    end
  endtask

  initial begin
    for (int n = 0; n < 127; n++) prbs[n] = (n < 7) ? 1'b1 : (prbs[n-7] ^ prbs[n-6]);
    test_reset();
    test_prbs();
    test_pattern();
    test_const();
    test_midrun();
    test_reset_midrun();
    test_drop_on_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
